// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg: shared state type and round-robin helper
// for the CORDIC request arbiter.
package cordic_arb_pkg;

    localparam int MAX_CH   = 8;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First set bit of valid at or after ptr, wrapping at n_ch.
    // The scan runs downward so the smallest offset wins last.
    function automatic int rr_pick(
        input logic [MAX_CH-1:0] valid,
        input int                ptr,
        input int                n_ch
    );
        int pick;
        int idx;
        pick = ptr;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n_ch) begin
                idx = ptr + i;
                if (idx >= n_ch) idx = idx - n_ch;
                if (((valid >> idx) & MAX_CH'(1)) != '0) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// cordic_tag_fifo: in-order channel-tag FIFO with
// first-word fall-through head.
module cordic_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty   = (cnt_q == '0);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
        head    = mem_q[rd_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read below cnt_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: packet-level round-robin sharing of one in-order
// arctan pipeline, with tag-routed result return.
module cordic_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 32
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_areset,
    input  logic [N_CH-1:0]              s_ch_tvalid,
    input  logic [N_CH-1:0]              s_ch_tlast,
    input  logic [N_CH*DATA_WIDTH-1:0]   s_ch_tdata,
    output logic [N_CH-1:0]              s_ch_tready,
    output logic                         m00_axis_tvalid,
    output logic                         m00_axis_tlast,
    output logic [DATA_WIDTH-1:0]        m00_axis_tdata,
    input  logic                         m00_axis_tready,
    input  logic                         s01_axis_tvalid,
    input  logic                         s01_axis_tlast,
    input  logic [DATA_WIDTH-1:0]        s01_axis_tdata,
    output logic                         s01_axis_tready,
    output logic [N_CH-1:0]              m_ch_tvalid,
    output logic [N_CH-1:0]              m_ch_tlast,
    output logic [N_CH*DATA_WIDTH-1:0]   m_ch_tdata,
    input  logic [N_CH-1:0]              m_ch_tready,
    output logic [$clog2(N_CH)-1:0]      grant_id,
    output logic                         busy,
    output logic [$clog2(TAG_DEPTH):0]   in_flight,
    output logic                         orphan_err
);
    import cordic_arb_pkg::*;

    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              orphan_q, orphan_d;
    logic [CH_W-1:0]   head;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic              issue, pop;

    cordic_tag_fifo #(
        .W     (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (s00_axis_aclk),
        .rst   (s00_axis_areset),
        .push  (issue),
        .pop   (pop),
        .din   (grant_q),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        m00_axis_tvalid = 1'b0;
        s_ch_tready     = '0;
        m00_axis_tdata  = s_ch_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m00_axis_tlast  = s_ch_tlast[grant_q];
        if (state_q == BUSY) begin
            m00_axis_tvalid      = s_ch_tvalid[grant_q] & ~full;
            s_ch_tready[grant_q] = m00_axis_tready & ~full;
        end
        issue = m00_axis_tvalid & m00_axis_tready;
    end

    // The grant is held until the tlast beat issues, whatever others do.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|s_ch_tvalid) begin
                    state_d = BUSY;
                    grant_d = CH_W'(rr_pick(MAX_CH'(s_ch_tvalid),
                                            int'(rr_q), N_CH));
                end
            end
            BUSY: begin
                if (issue && m00_axis_tlast) begin
                    state_d = IDLE;
                    rr_d    = (grant_q == CH_W'(N_CH - 1)) ?
                              '0 : grant_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Results with no recorded owner are accepted and dropped.
    always_comb begin
        m_ch_tvalid     = '0;
        m_ch_tlast      = '0;
        s01_axis_tready = 1'b1;
        pop             = 1'b0;
        orphan_d        = orphan_q;
        if (!empty) begin
            m_ch_tvalid[head] = s01_axis_tvalid;
            m_ch_tlast[head]  = s01_axis_tlast;
            s01_axis_tready   = m_ch_tready[head];
            pop               = s01_axis_tvalid & m_ch_tready[head];
        end else if (s01_axis_tvalid) begin
            orphan_d = 1'b1;
        end
    end

    assign m_ch_tdata = {N_CH{s01_axis_tdata}};
    assign grant_id   = grant_q;
    assign busy       = (state_q == BUSY);
    assign in_flight  = count;
    assign orphan_err = orphan_q;

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: randomized traffic through a latency-model datapath,
// per-channel scoreboard plus directed arbitration/stall/orphan scenarios.
module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TD  = 4;
    localparam int LAT = 3;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        beat_t b;
        int    t;
    } dp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_ch_tvalid = '0;
    logic [N-1:0]    s_ch_tlast = '0;
    logic [N*DW-1:0] s_ch_tdata = '0;
    logic [N-1:0]    s_ch_tready;
    logic            m00_axis_tvalid, m00_axis_tlast;
    logic [DW-1:0]   m00_axis_tdata;
    logic            m00_axis_tready = 1'b0;
    logic            s01_axis_tvalid = 1'b0;
    logic            s01_axis_tlast = 1'b0;
    logic [DW-1:0]   s01_axis_tdata = '0;
    logic            s01_axis_tready;
    logic [N-1:0]    m_ch_tvalid, m_ch_tlast;
    logic [N*DW-1:0] m_ch_tdata;
    logic [N-1:0]    m_ch_tready = '0;
    logic [1:0]      grant_id;
    logic            busy;
    logic [2:0]      in_flight;
    logic            orphan_err;

    cordic_arbiter #(
        .N_CH       (N),
        .DATA_WIDTH (DW),
        .TAG_DEPTH  (TD)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s_ch_tvalid     (s_ch_tvalid),
        .s_ch_tlast      (s_ch_tlast),
        .s_ch_tdata      (s_ch_tdata),
        .s_ch_tready     (s_ch_tready),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tready (m00_axis_tready),
        .s01_axis_tvalid (s01_axis_tvalid),
        .s01_axis_tlast  (s01_axis_tlast),
        .s01_axis_tdata  (s01_axis_tdata),
        .s01_axis_tready (s01_axis_tready),
        .m_ch_tvalid     (m_ch_tvalid),
        .m_ch_tlast      (m_ch_tlast),
        .m_ch_tdata      (m_ch_tdata),
        .m_ch_tready     (m_ch_tready),
        .grant_id        (grant_id),
        .busy            (busy),
        .in_flight       (in_flight),
        .orphan_err      (orphan_err)
    );

    always #5 clk = ~clk;

    beat_t src_q [N][$];
    beat_t exp_q [N][$];
    dp_t   dp_q [$];
    int    vprob [N];
    int    sprob [N];
    int    hold [N];
    int    rdy_prob, out_prob;
    bit    orphan_inj;
    int    cyc, model_if, last_pop;
    int    issue_ch [$];
    int    issue_cyc [$];
    int    n_chk, n_fail;
    int    e_nf;
    dp_t   e_dp;
    beat_t m_b;

    // Stand-in for the arctan transform: any fixed bijection will do.
    function automatic logic [DW-1:0] f(input logic [DW-1:0] d);
        return {d[15:0], d[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit pending();
        for (int c = 0; c < N; c++)
            if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic send(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = (i == len - 1);
            src_q[c].push_back(b);
            b.data = f(b.data);
            exp_q[c].push_back(b);
        end
    endtask

    task automatic drain(input int budget, output int pk);
        int k;
        k  = 0;
        pk = 0;
        while (pending() && k < budget) begin
            cyc_wait(1);
            k++;
            if (int'(in_flight) > pk) pk = int'(in_flight);
        end
        chk("drain_done", 64'(pending()), 0);
    endtask

    task automatic chk_seq(input string nm, input int base,
                           input int exp [$], input int gaps [$]);
        chk({nm, "_len"}, issue_ch.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < issue_ch.size()) begin
                chk({nm, "_ch"}, issue_ch[base + i], exp[i]);
                if (i > 0 && gaps.size() >= i)
                    chk({nm, "_gap"},
                        issue_cyc[base + i] - issue_cyc[base + i - 1],
                        gaps[i - 1]);
            end
        end
    endtask

    task automatic wait_issues(input int target);
        int k;
        k = 0;
        while (issue_ch.size() < target && k < 50) begin
            cyc_wait(1);
            k++;
        end
        chk("wait_issue", 64'(issue_ch.size() >= target), 1);
    endtask

    // Sources, datapath model and sinks: drive on negedge, sample
    // handshakes just before the rising edge.
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            s_ch_tvalid[c] = src_q[c].size() > 0 && hold[c] == 0 &&
                             $urandom_range(99) < vprob[c];
            if (hold[c] > 0) hold[c]--;
            s_ch_tdata[c*DW +: DW] = (src_q[c].size() > 0) ?
                                     src_q[c][0].data : $urandom;
            s_ch_tlast[c] = (src_q[c].size() > 0) ? src_q[c][0].last : 1'b0;
            m_ch_tready[c] = $urandom_range(99) < sprob[c];
        end
        m00_axis_tready = $urandom_range(99) < rdy_prob;
        if (orphan_inj) begin
            s01_axis_tvalid = 1'b1;
            s01_axis_tdata  = $urandom;
            s01_axis_tlast  = 1'b0;
        end else if (dp_q.size() > 0 && dp_q[0].t <= cyc &&
                     $urandom_range(99) < out_prob) begin
            s01_axis_tvalid = 1'b1;
            s01_axis_tdata  = dp_q[0].b.data;
            s01_axis_tlast  = dp_q[0].b.last;
        end else begin
            s01_axis_tvalid = 1'b0;
        end
        #4;
        if (rst) begin
            for (int c = 0; c < N; c++) src_q[c].delete();
            dp_q.delete();
            model_if = 0;
        end else begin
            chk("in_flight", in_flight, model_if);
            if (model_if == TD) chk("full_no_issue", m00_axis_tvalid, 0);
            if (s01_axis_tvalid && s01_axis_tready) begin
                if (!orphan_inj) void'(dp_q.pop_front());
                if (model_if > 0) begin
                    model_if--;
                    last_pop = cyc;
                end
            end
            e_nf = 0;
            for (int c = 0; c < N; c++) begin
                if (s_ch_tvalid[c] && s_ch_tready[c]) begin
                    e_nf++;
                    issue_ch.push_back(c);
                    issue_cyc.push_back(cyc);
                    void'(src_q[c].pop_front());
                end
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                e_dp.b.data = f(m00_axis_tdata);
                e_dp.b.last = m00_axis_tlast;
                e_dp.t      = cyc + LAT;
                dp_q.push_back(e_dp);
                model_if++;
            end
            if (e_nf != 0 || (m00_axis_tvalid && m00_axis_tready))
                chk("issue_hs", e_nf,
                    int'(m00_axis_tvalid && m00_axis_tready));
        end
        cyc++;
    end

    // Result monitor: each channel's results must match its own
    // request order, and nothing may appear on an idle channel.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            for (int c = 0; c < N; c++) exp_q[c].delete();
        end else begin
            for (int c = 0; c < N; c++) begin
                if (m_ch_tvalid[c]) begin
                    chk("route", 64'(exp_q[c].size() > 0), 1);
                    if (exp_q[c].size() > 0 && m_ch_tready[c]) begin
                        m_b = exp_q[c].pop_front();
                        chk("res_data", m_ch_tdata[c*DW +: DW], m_b.data);
                        chk("res_last", m_ch_tlast[c], m_b.last);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pk;
        int eq [$];
        int gq [$];
        for (int c = 0; c < N; c++) begin
            vprob[c] = 100;
            sprob[c] = 100;
            hold[c]  = 0;
        end
        rdy_prob   = 100;
        out_prob   = 100;
        orphan_inj = 1'b0;

        cyc_wait(3);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_inflight", in_flight, 0);
        chk("rst_orphan", orphan_err, 0);
        chk("rst_m00_valid", m00_axis_tvalid, 0);
        chk("rst_s_ready", s_ch_tready, 0);
        chk("rst_m_valid", m_ch_tvalid, 0);
        chk("rst_s01_ready", s01_axis_tready, 1);
        rst = 1'b0;
        cyc_wait(2);
        chk("idle_busy", busy, 0);

        // Single channel, three beats.
        base = issue_ch.size();
        send(2, 3);
        drain(200, pk);
        chk("single_peak", pk, 3);
        eq = '{2, 2, 2};
        gq = '{1, 1};
        chk_seq("single", base, eq, gq);
        chk("single_empty", in_flight, 0);

        // Round robin from reset with one bubble between packets.
        rst = 1'b1;
        cyc_wait(2);
        base = issue_ch.size();
        send(0, 2);
        send(1, 2);
        send(3, 2);
        rst = 1'b0;
        drain(200, pk);
        eq = '{0, 0, 1, 1, 3, 3};
        gq = '{1, 2, 1, 2, 1};
        chk_seq("rr", base, eq, gq);
        base = issue_ch.size();
        send(1, 1);
        send(0, 1);
        drain(200, pk);
        eq = '{0, 1};
        gq = '{2};
        chk_seq("rr_wrap", base, eq, gq);

        // Grant lock while the owner pauses mid-packet.
        base = issue_ch.size();
        send(1, 4);
        wait_issues(base + 1);
        hold[1] = 4;
        send(0, 2);
        drain(200, pk);
        eq = '{1, 1, 1, 1, 0, 0};
        gq = '{};
        chk_seq("lock", base, eq, gq);
        if (issue_cyc.size() >= base + 4)
            chk("lock_pause",
                64'(issue_cyc[base + 3] - issue_cyc[base] >= 7), 1);

        // Tag FIFO full stall.
        out_prob = 0;
        base = issue_ch.size();
        send(0, 8);
        cyc_wait(12);
        chk("full_issued", issue_ch.size() - base, 4);
        chk("full_inflight", in_flight, 4);
        chk("full_ready", s_ch_tready[0], 0);
        chk("full_m00", m00_axis_tvalid, 0);
        out_prob = 100;
        cyc_wait(1);
        out_prob = 0;
        cyc_wait(3);
        chk("full_one_more", issue_ch.size() - base, 5);
        if (issue_cyc.size() >= base + 5)
            chk("full_next_cycle", issue_cyc[base + 4], last_pop + 1);
        out_prob = 100;
        drain(400, pk);

        // Output backpressure holds the shared return path.
        sprob[1] = 0;
        send(1, 3);
        send(2, 2);
        cyc_wait(15);
        chk("bp_s01_valid", s01_axis_tvalid, 1);
        chk("bp_s01_ready", s01_axis_tready, 0);
        chk("bp_m_valid", m_ch_tvalid, 4'b0010);
        chk("bp_inflight", in_flight, 4);
        sprob[1] = 100;
        drain(400, pk);

        // Randomized traffic.
        for (int c = 0; c < N; c++) begin
            vprob[c] = $urandom_range(100, 50);
            sprob[c] = $urandom_range(100, 40);
        end
        rdy_prob = $urandom_range(100, 40);
        out_prob = $urandom_range(100, 40);
        for (int p = 0; p < 40; p++)
            send($urandom_range(N - 1), $urandom_range(5, 1));
        drain(5000, pk);
        for (int c = 0; c < N; c++) begin
            vprob[c] = 100;
            sprob[c] = 100;
        end
        rdy_prob = 100;
        out_prob = 100;
        cyc_wait(2);

        // Orphan result, stickiness, and clearing by a mid-packet reset.
        chk("orph_pre_empty", in_flight, 0);
        orphan_inj = 1'b1;
        cyc_wait(1);
        orphan_inj = 1'b0;
        cyc_wait(1);
        chk("orph_set", orphan_err, 1);
        cyc_wait(5);
        chk("orph_sticky", orphan_err, 1);
        out_prob = 0;
        base = issue_ch.size();
        send(2, 6);
        wait_issues(base + 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_orphan", orphan_err, 0);
        chk("mid_rst_inflight", in_flight, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m00", m00_axis_tvalid, 0);
        chk("mid_rst_ready", s_ch_tready, 0);
        cyc_wait(2);
        rst = 1'b0;
        out_prob = 100;
        cyc_wait(2);
        orphan_inj = 1'b1;
        cyc_wait(1);
        orphan_inj = 1'b0;
        cyc_wait(1);
        chk("orph_after_rst", orphan_err, 1);
        chk("post_rst_m_valid", m_ch_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one pipelined CORDIC arctan datapath among N_CH AXI-Stream requesters. Packets are admitted whole in round-robin order and each accepted beat's channel ID is recorded in an in-order tag FIFO. Results returning from the datapath are routed back to the owning channel. The block sits between the per-channel sample sources and the single arctan pipeline, which is strictly in-order and propagates tlast per beat.

## Interface
- N_CH, 4: number of requester channels (2..8)
- DATA_WIDTH, 32: beat width, packed {y[31:16], x[15:0]} in, phase out
- TAG_DEPTH, 32: maximum beats in flight inside the datapath; power of two, ≥ datapath depth
- s00_axis_aclk  in  1  single clock for all ports
- s00_axis_areset  in  1  asynchronous, active-high reset
- s_ch_tvalid / s_ch_tlast  in  N_CH  per-channel request valid / last
- s_ch_tdata  in  N_CH*DATA_WIDTH  per-channel request data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_ch_tready  out  N_CH  per-channel request ready
- m00_axis_tvalid / tlast / tdata  out  1/1/DATA_WIDTH  beat to datapath input
- m00_axis_tready  in  1  datapath input ready
- s01_axis_tvalid / tlast / tdata  in  1/1/DATA_WIDTH  result from datapath output
- s01_axis_tready  out  1  result ready
- m_ch_tvalid / m_ch_tlast  out  N_CH  per-channel result valid / last
- m_ch_tdata  out  N_CH*DATA_WIDTH  per-channel result data, same packing as s_ch_tdata
- m_ch_tready  in  N_CH  per-channel result ready
- grant_id  out  $clog2(N_CH)  current owner, valid only in BUSY
- busy  out  1  state == BUSY
- in_flight  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy
- orphan_err  out  1  sticky flag: result arrived with tag FIFO empty

## Operation
- States: IDLE and BUSY.
- IDLE: all s_ch_tready = 0 and m00_axis_tvalid = 0. If any s_ch_tvalid is set, pick the first valid channel scanning upward from rr_ptr with wrap (N_CH-1 → 0). Register grant_id and go to BUSY.
- BUSY: forward granted channel combinationally:
  - m00_axis_tvalid = s_ch_tvalid[g] & ~full
  - s_ch_tready[g] = m00_axis_tready & ~full
  - tdata and tlast pass through unmodified
  - all other s_ch_tready = 0
- Beat issued = m00_axis_tvalid & m00_axis_tready. Each issued beat pushes g into the tag FIFO.
- Issued beat with tlast: rr_ptr ← (g+1) mod N_CH, go to IDLE. The grant is held for the whole packet regardless of other channels' valids.
- Return path, FIFO non-empty with head h: m_ch_tvalid[h] = s01_axis_tvalid and s01_axis_tready = m_ch_tready[h]; data and tlast pass through; other m_ch_tvalid = 0. Each accepted result pops the FIFO.
- Return path, FIFO empty: s01_axis_tready = 1 and no m_ch_tvalid asserts. Any s01_axis_tvalid in this state sets orphan_err, and the beat is dropped.
- full = (in_flight == TAG_DEPTH). Issue stalls while full; a pop in the same cycle does not unblock that cycle's issue.
- Simultaneous push and pop leaves in_flight unchanged. Pointers wrap modulo TAG_DEPTH.
- A granted channel that drops tvalid mid-packet keeps the grant. There is no timeout.

## Timing
- Reset values:
  - IDLE, rr_ptr = 0, grant_id = 0, busy = 0, in_flight = 0, orphan_err = 0
  - all s_ch_tready = 0, m00_axis_tvalid = 0, m_ch_tvalid = 0, s01_axis_tready = 1
- Arbitration latency: a valid request seen in IDLE in cycle n gets its first beat eligible for issue in cycle n+1.
- Inter-packet bubble: exactly 1 cycle (the IDLE cycle) after each tlast beat.
- Data paths add zero cycles; all forwarding is combinational. Registers are state, grant_id, rr_ptr, the tag FIFO and orphan_err.
- Reset mid-packet or mid-flight: all state clears asynchronously and in-flight tags are discarded. The datapath must be reset in the same cycle; results arriving afterwards set orphan_err.

## Structure
- Package cordic_arb_pkg:
  - state enum (IDLE, BUSY)
  - function rr_pick(valid, ptr) returning the next channel
  - localparam CH_W = $clog2(N_CH)
- Sub-module cordic_tag_fifo: synchronous FIFO of CH_W-bit entries, depth TAG_DEPTH, with push, pop, head, count and full. The head read is combinational (first-word fall-through).

## Test plan
- Single channel: ch2 sends a 3-beat packet (tlast on beat 3) with datapath ready; each beat reaches the datapath. After datapath latency, 3 results appear only on m_ch[2] with tlast on result 3. in_flight rises to 3 and then returns to 0.
- Round-robin: ch0, ch1 and ch3 all hold 2-beat packets from reset. Issue order is ch0, ch1, ch3, with 1 IDLE cycle between packets. Then rr_ptr = 0.
- Grant lock: ch1 drops tvalid for 4 cycles mid-packet while ch0 is valid. No ch0 beat issues until ch1's tlast beat is issued.
- Full stall: TAG_DEPTH = 4, s01_axis_tvalid held low, ch0 streams 8 beats. Exactly 4 issue, then s_ch_tready[0] stays 0. After one result is popped, one more beat issues the next cycle.
- Output backpressure: m_ch_tready[1] is low while the head tag = 1. Then s01_axis_tready = 0 and the FIFO is not popped. Releasing it delivers results in original order.
- Orphan/reset: drive s01_axis_tvalid with in_flight = 0. Then orphan_err = 1 and stays 1 until s00_axis_areset; asserting reset mid-packet clears it.
